// File: rtl/adder_feed_pkg.sv
// Shared widths and pixel type for the approximate-adder operand feeder.
package adder_feed_pkg;

  localparam int PIX_W     = 4;
  localparam int SUM_W     = PIX_W + 1;
  localparam int DEPTH_DEF = 4;

  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/adder_operand_feeder_fifo.sv
// pixel_fifo: small synchronous FIFO holding one pixel stream ahead of pairing.
// A full FIFO refuses a push even when popped in the same cycle; no bypass path.
module pixel_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adder_operand_feeder.sv
// Pairs two buffered pixel streams, drives the adder operands and registers the sum.
// Build option ADDER_FEED_AVG_EN: capture the truncated average (sum >> 1) instead of the sum.
module adder_operand_feeder #(
  parameter int PIX_W = adder_feed_pkg::PIX_W,
  parameter int SUM_W = adder_feed_pkg::SUM_W,
  parameter int DEPTH = adder_feed_pkg::DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [PIX_W-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [PIX_W-1:0] b_data,
  output logic             b_ready,
  output logic [PIX_W-1:0] op_a,
  output logic [PIX_W-1:0] op_b,
  input  logic [SUM_W-1:0] sum_in,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt
);

  import adder_feed_pkg::*;

  logic             full_a, empty_a, full_b, empty_b;
  logic [PIX_W-1:0] head_a, head_b;
  logic             pair_ok;
  logic             fire;
  logic [SUM_W-1:0] result;

  pixel_fifo #(.W(PIX_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (a_valid),
    .din   (a_data),
    .pop   (fire),
    .full  (full_a),
    .empty (empty_a),
    .head  (head_a)
  );

  pixel_fifo #(.W(PIX_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (b_valid),
    .din   (b_data),
    .pop   (fire),
    .full  (full_b),
    .empty (empty_b),
    .head  (head_b)
  );

  assign a_ready = rst_n && !full_a;
  assign b_ready = rst_n && !full_b;

  // Operands stay at zero until a pair exists, keeping the adder array quiet.
  assign pair_ok = !empty_a && !empty_b;
  assign op_a    = pair_ok ? head_a : '0;
  assign op_b    = pair_ok ? head_b : '0;
  assign fire    = pair_ok && (!out_valid || out_ready);

`ifdef ADDER_FEED_AVG_EN
  assign result = {1'b0, sum_in[SUM_W-1:1]};
`else
  assign result = sum_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      pair_cnt  <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= result;
      pair_cnt  <= pair_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_operand_feeder.sv
// Directed bench for adder_operand_feeder with an exact adder stub; a second
// instance with a 4-bit pair counter shares all inputs to exercise counter wrap.
module tb_adder_operand_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, out_ready;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid;
  logic [3:0] op_a, op_b;
  logic [4:0] sum_in, out_data;
  logic [15:0] pair_cnt;

  logic       a_ready_w, b_ready_w, out_valid_w;
  logic [3:0] op_a_w, op_b_w;
  logic [4:0] sum_in_w, out_data_w;
  logic [3:0] pair_cnt_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign sum_in   = {1'b0, op_a} + {1'b0, op_b};
  assign sum_in_w = {1'b0, op_a_w} + {1'b0, op_b_w};

  adder_operand_feeder u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .op_a(op_a), .op_b(op_b), .sum_in(sum_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .pair_cnt(pair_cnt)
  );

  adder_operand_feeder #(.CNT_W(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready_w),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready_w),
    .op_a(op_a_w), .op_b(op_b_w), .sum_in(sum_in_w),
    .out_valid(out_valid_w), .out_data(out_data_w), .out_ready(out_ready),
    .pair_cnt(pair_cnt_w)
  );

  function automatic logic [4:0] exp_sum(input int a, input int b);
`ifdef ADDER_FEED_AVG_EN
    return 5'((a + b) >> 1);
`else
    return 5'(a + b);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_data = '0; b_data = '0;
    #2;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 5'd0 || pair_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_out: valid=%b data=%0d cnt=%0d, required 0/0/0", out_valid, out_data, pair_cnt);
    end
    tests++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: a_ready=%b b_ready=%b, required 0/0", a_ready, b_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++;
    if (a_ready !== 1'b1 || op_a !== 4'd0 || op_b !== 4'd0) begin
      fails++;
      $display("FAIL post_reset: a_ready=%b op_a=%0d op_b=%0d, required 1/0/0", a_ready, op_a, op_b);
    end
  endtask

  task automatic test_single_pair();
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 4'd9;
    b_valid = 1'b1; b_data = 4'd10;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || op_a !== 4'd9 || op_b !== 4'd10) begin
      fails++;
      $display("FAIL single_ops: valid=%b op_a=%0d op_b=%0d, required 0/9/10", out_valid, op_a, op_b);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp_sum(9, 10) || pair_cnt !== 16'd1) begin
      fails++;
      $display("FAIL single_out: valid=%b data=%0d cnt=%0d, required 1/%0d/1", out_valid, out_data, pair_cnt, exp_sum(9, 10));
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || out_data !== exp_sum(9, 10)) begin
      fails++;
      $display("FAIL single_drop: valid=%b data=%0d, required 0/%0d", out_valid, out_data, exp_sum(9, 10));
    end
  endtask

  task automatic test_back_to_back();
    int av[3] = '{11, 12, 13};
    int bv[3] = '{12, 13, 14};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_data = 4'(av[i]);
      b_valid = 1'b1; b_data = 4'(bv[i]);
      step();
      if (i > 0) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp_sum(av[i-1], bv[i-1])) begin
          fails++;
          $display("FAIL b2b_%0d: valid=%b data=%0d, required 1/%0d", i - 1, out_valid, out_data, exp_sum(av[i-1], bv[i-1]));
        end
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp_sum(13, 14) || pair_cnt !== 16'd4) begin
      fails++;
      $display("FAIL b2b_2: valid=%b data=%0d cnt=%0d, required 1/%0d/4", out_valid, out_data, pair_cnt, exp_sum(13, 14));
    end
    step();
  endtask

  task automatic test_stall();
    int pa[6] = '{9, 1, 3, 5, 7, 2};
    int pb[6] = '{10, 2, 4, 6, 8, 2};
    logic [4:0] got[6];
    int idx = 0;
    int ng = 0;
    logic acc;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      a_valid = (idx < 6); b_valid = (idx < 6);
      if (idx < 6) begin a_data = 4'(pa[idx]); b_data = 4'(pb[idx]); end
      acc = a_ready && b_ready && (idx < 6);
      step();
      if (acc) idx++;
    end
    tests++;
    if (idx != 5 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_accepts: accepted=%0d a_ready=%b b_ready=%b, required 5/0/0", idx, a_ready, b_ready);
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp_sum(9, 10)) begin
      fails++;
      $display("FAIL stall_hold: valid=%b data=%0d, required 1/%0d", out_valid, out_data, exp_sum(9, 10));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && ng < 6; c++) begin
      a_valid = (idx < 6); b_valid = (idx < 6);
      if (idx < 6) begin a_data = 4'(pa[idx]); b_data = 4'(pb[idx]); end
      acc = a_ready && b_ready && (idx < 6);
      if (out_valid) begin got[ng] = out_data; ng++; end
      step();
      if (acc) idx++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tests++;
    if (ng != 6) begin
      fails++;
      $display("FAIL stall_drain_count: outputs=%0d, required 6", ng);
    end
    for (int k = 0; k < ng; k++) begin
      tests++;
      if (got[k] !== exp_sum(pa[k], pb[k])) begin
        fails++;
        $display("FAIL stall_drain_%0d: data=%0d, required %0d", k, got[k], exp_sum(pa[k], pb[k]));
      end
    end
    step(); step();
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'd10) begin
      fails++;
      $display("FAIL stall_end: valid=%b cnt=%0d, required 0/10", out_valid, pair_cnt);
    end
  endtask

  task automatic test_skew();
    int av[4] = '{3, 5, 7, 9};
    logic [4:0] got[4];
    int ng = 0;
    out_ready = 1'b1;
    b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1; a_data = 4'(av[k]);
      step();
    end
    a_valid = 1'b0;
    tests++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1 || op_a !== 4'd0 || op_b !== 4'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL skew_wait: a_ready=%b b_ready=%b op_a=%0d op_b=%0d valid=%b, required 0/1/0/0/0",
               a_ready, b_ready, op_a, op_b, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      b_valid = 1'b1; b_data = 4'(k + 1);
      step();
      if (out_valid && ng < 4) begin got[ng] = out_data; ng++; end
    end
    b_valid = 1'b0;
    for (int c = 0; c < 10 && ng < 4; c++) begin
      step();
      if (out_valid) begin got[ng] = out_data; ng++; end
    end
    tests++;
    if (ng != 4) begin
      fails++;
      $display("FAIL skew_count: outputs=%0d, required 4", ng);
    end
    for (int k = 0; k < ng; k++) begin
      tests++;
      if (got[k] !== exp_sum(av[k], k + 1)) begin
        fails++;
        $display("FAIL skew_order_%0d: data=%0d, required %0d", k, got[k], exp_sum(av[k], k + 1));
      end
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'd14) begin
      fails++;
      $display("FAIL skew_end: valid=%b cnt=%0d, required 0/14", out_valid, pair_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1; a_data = 4'(k + 1);
      b_valid = 1'b1; b_data = 4'(k + 2);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || u_dut.u_fifo_a.count !== 3'd3) begin
      fails++;
      $display("FAIL rst_mid_pre: valid=%b occ_a=%0d, required 1/3", out_valid, u_dut.u_fifo_a.count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'd0 || out_data !== 5'd0) begin
      fails++;
      $display("FAIL rst_mid_out: valid=%b cnt=%0d data=%0d, required 0/0/0", out_valid, pair_cnt, out_data);
    end
    tests++;
    if (u_dut.u_fifo_a.count !== 3'd0 || u_dut.u_fifo_b.count !== 3'd0 || a_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_fifo: occ_a=%0d occ_b=%0d a_ready=%b, required 0/0/0",
               u_dut.u_fifo_a.count, u_dut.u_fifo_b.count, a_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0 || pair_cnt !== 16'd0 || pair_cnt_w !== 4'd0 || a_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_after: stale=%b cnt=%0d cnt_w=%0d a_ready=%b, required 0/0/0/1",
               seen, pair_cnt, pair_cnt_w, a_ready);
    end
  endtask

  task automatic test_cnt_wrap();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      a_valid = 1'b1; a_data = 4'(k);
      b_valid = 1'b1; b_data = 4'd1;
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step(); step();
    tests++;
    if (pair_cnt_w !== 4'd1 || pair_cnt !== 16'd17) begin
      fails++;
      $display("FAIL cnt_wrap: cnt_w=%0d cnt=%0d, required 1/17", pair_cnt_w, pair_cnt);
    end
    tests++;
    if (out_valid !== 1'b0 || out_data !== exp_sum(0, 1)) begin
      fails++;
      $display("FAIL cnt_wrap_last: valid=%b data=%0d, required 0/%0d", out_valid, out_data, exp_sum(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_stall();
    test_skew();
    test_reset_mid();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
